// File: rtl/comparador_serial_ctrl_if.sv
// rtl/comparador_serial_ctrl_if.sv - request/result bundle for the bit-serial comparator
interface comparador_serial_ctrl_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic          abort;
    logic [N-1:0]  wordA;
    logic [N-1:0]  wordB;
    logic          busy;
    logic          done;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [IW-1:0] bit_idx;

    modport master (
        output start, abort, wordA, wordB,
        input  busy, done, gt, eq, lt, bit_idx
    );

    modport slave (
        input  start, abort, wordA, wordB,
        output busy, done, gt, eq, lt, bit_idx
    );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// rtl/comparador_serial_ctrl.sv - bit-serial LSB-first unsigned magnitude comparator
module comparador_serial_ctrl #(
    parameter int N = 8
) (
    input logic                     clk,
    input logic                     reset,
    comparador_serial_ctrl_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          g_q, g_d;
    logic          l_q, l_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic a_bit, b_bit, g_next, l_next;

    // One comparator cell: a higher-order differing bit overrides the history in g/l.
    always_comb begin
        a_bit  = a_q[0];
        b_bit  = b_q[0];
        g_next = (a_bit & ~b_bit) | (~(a_bit ^ b_bit) & g_q);
        l_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & l_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        l_d     = l_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.wordA;
                    b_d     = bus.wordB;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Abort wins even on the final bit; results keep the previous comparison.
                if (bus.abort) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    g_d = g_next;
                    l_d = l_next;
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        gt_d    = g_next;
                        lt_d    = l_next;
                        eq_d    = ~(g_next | l_next);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            l_q     <= l_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.gt      = gt_q;
    assign bus.eq      = eq_q;
    assign bus.lt      = lt_q;
    assign bus.bit_idx = idx_q;
endmodule

// File: doc/comparador_serial_ctrl.md
COMPARADOR_SERIAL_CTRL -- requirements
Module: comparador_serial_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 abort  input  1  cancel scan in progress; sampled only in SCAN.
REQ-006 wordA  input  N  operand A, unsigned; sampled on the accepting start edge only.
REQ-007 wordB  input  N  operand B, unsigned; sampled on the accepting start edge only.
REQ-008 busy  output  1  high while state is SCAN.
REQ-009 done  output  1  one-cycle pulse when a result becomes valid.
REQ-010 gt  output  1  registered result A > B.
REQ-011 eq  output  1  registered result A == B.
REQ-012 lt  output  1  registered result A < B.
REQ-013 bit_idx  output  clog2(N)  bit position being examined (0 = LSB).

Function
REQ-014 The block SHALL compare wordA and wordB bit-serially, right to left (LSB first), one bit per clk cycle, using a single-bit typical cell plus two state flags (g, l).
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-016 IDLE: if start=1 at an edge, latch wordA/wordB into internal shift registers, clear g and l, set bit_idx=0, go to SCAN; otherwise stay.
REQ-017 SCAN, each edge, with a=A[bit_idx], b=B[bit_idx]: g <= (a & ~b) | (~(a ^ b) & g); l <= (~a & b) | (~(a ^ b) & l); bit_idx increments.
REQ-018 SCAN: on the edge processing bit_idx = N-1, go to DONE and load gt=g_next, lt=l_next, eq=~(g_next | l_next); bit_idx wraps to 0.
REQ-019 DONE: done=1 for exactly that one cycle; next edge returns to IDLE unconditionally.
REQ-020 Latency: start accepted at edge k -> done high during cycle after edge k+N (N+1 edges); start can be re-accepted at edge k+N+2 at the earliest.
REQ-021 start while in SCAN or DONE SHALL be ignored; no queuing.
REQ-022 Operand changes on wordA/wordB after acceptance SHALL not affect the running comparison.
REQ-023 abort=1 in SCAN SHALL return to IDLE on that edge, clear bit_idx, assert no done, and leave gt/eq/lt unchanged from the previous result.
REQ-024 abort has priority over the final-bit transition of REQ-018 when both occur on the same edge.
REQ-025 gt, eq, lt SHALL hold their value from the last completed comparison until the next one completes; exactly one of them is 1 at any time.
REQ-026 The result SHALL equal the unsigned magnitude comparison of the latched operands for every operand pair.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, busy=0, done=0, bit_idx=0, g=l=0, gt=0, lt=0, eq=1.
REQ-028 reset asserted mid-SCAN SHALL discard the comparison with no done pulse; after release the block accepts start normally.

Verification
REQ-029 N=8, A=0xA5, B=0x5A, start 1 cycle -> busy 8 cycles, done pulse after edge k+8, gt=1 eq=0 lt=0.
REQ-030 N=8, A=0x7F, B=0x80 -> lt=1 (MSB decides over lower bits); A=0x3C, B=0x3C -> eq=1.
REQ-031 N=8, A=0x01, B=0x00, then wordA changed to 0x00 during SCAN and start pulsed mid-scan -> single done, gt=1, no second comparison.
REQ-032 Scan of A=0xFF, B=0x00 after a prior lt result, abort at bit_idx=5 -> IDLE, no done, lt still 1; reset at bit_idx=3 of a new scan -> all outputs at REQ-027 values immediately.
REQ-033 N=8, 1000 random operand pairs back-to-back (start re-asserted at earliest legal edge) -> every result matches a reference unsigned compare; exactly one of gt/eq/lt high every cycle.
